// File: rtl/system_pio_pkg.sv
// system_pio_pkg: shared constants and types for the system PIO blocks.
//   - Register address map for the button PIO slave.
//   - Edge-mode encodings selecting which debounced transitions latch.
//   - Bus request struct used internally by the register file.
package system_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RSVD     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_mode_e;

  // Decoded slave access for one clock.
  typedef struct packed {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
  } bus_req_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one input channel -- two-flop synchroniser, optional
// debounce counter and the accepted (stable) level.
// Build option: BTN_PIO_DEBOUNCE_EN enables the counter; without it the
// stable level is simply the synchroniser output.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   din           raw asynchronous input
//   level         accepted level
//   change        level will toggle on the coming clock edge
module btn_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic change
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("btn_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  logic s1, s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= IDLE_LEVEL;
      s2 <= IDLE_LEVEL;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

`ifdef BTN_PIO_DEBOUNCE_EN
  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          stable;

  // Accept only after s2 has disagreed with stable for DEBOUNCE_CYCLES
  // consecutive clocks; any agreement in between restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= IDLE_LEVEL;
    end else if (s2 == stable) begin
      cnt    <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= s2;
      cnt    <= '0;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end

  assign level  = stable;
  assign change = (s2 != stable) && (cnt == CNT_LAST);
`else
  assign level  = s2;
  assign change = (s1 != s2);
`endif

endmodule

// File: rtl/system_button_pio.sv
// system_button_pio: Avalon-MM input PIO for push-buttons/switches.
// Synchronises and debounces WIDTH inputs, latches qualified edges into a
// write-1-to-clear capture register and raises a masked level interrupt.
// Build option: BTN_PIO_DEBOUNCE_EN enables per-channel debounce counters.
// Ports:
//   clk, reset_n              clock, async active-low reset
//   address, chipselect,
//   write_n, writedata        Avalon-MM slave write/select
//   in_port[WIDTH]            raw button inputs
//   readdata[32]              registered read data (1 clock latency)
//   irq                       |(EDGE_CAPTURE & IRQ_MASK)
// Registers: 0 DATA (RO), 1 reserved, 2 IRQ_MASK (RW), 3 EDGE_CAPTURE (RW1C).
module system_button_pio
  import system_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_MODE       = 0,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("system_button_pio: WIDTH must be 1..32");
  end
  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
    $error("system_button_pio: EDGE_MODE must be 0, 1 or 2");
  end

  localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE[1:0]);

  bus_req_t         req;
  logic [WIDTH-1:0] level, change;
  logic [WIDTH-1:0] edge_set, edge_clr;
  logic [WIDTH-1:0] irq_mask, edge_cap;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign req = '{wr: chipselect & ~write_n, addr: address, data: writedata};
  assign unused_wdata = ^req.data;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL[i])
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .level   (level[i]),
      .change  (change[i])
    );
  end

  // change flags the edge on which level toggles, so the capture bit lands
  // on the same clock as the new level. Current level 0 means a rise.
  always_comb begin
    edge_set = '0;
    case (MODE)
      EDGE_RISE: edge_set = change & ~level;
      EDGE_FALL: edge_set = change &  level;
      default:   edge_set = change;
    endcase
  end

  assign edge_clr = (req.wr && req.addr == ADDR_EDGE_CAP) ? req.data[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:     rd_mux[WIDTH-1:0] = level;
      ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAP: rd_mux[WIDTH-1:0] = edge_cap;
      default:       rd_mux = '0;
    endcase
  end

  // Set wins over a simultaneous clear so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      edge_cap <= '0;
      readdata <= '0;
    end else begin
      if (req.wr && req.addr == ADDR_IRQ_MASK) irq_mask <= req.data[WIDTH-1:0];
      edge_cap <= (edge_cap & ~edge_clr) | edge_set;
      readdata <= rd_mux;
    end
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_system_button_pio.sv
// tb_system_button_pio: two instances (rising-edge/idle-low and
// any-edge/idle-high, DEBOUNCE_CYCLES=8) on a shared bus, checked every
// clock against a behavioural model, plus directed checks.
module tb_system_button_pio;
  import system_pio_pkg::*;

  localparam int W = 4;
  localparam int D = 8;
`ifdef BTN_PIO_DEBOUNCE_EN
  localparam bit DB  = 1'b1;
  localparam int LAT = D + 2;
`else
  localparam bit DB  = 1'b0;
  localparam int LAT = 2;
`endif
  localparam logic [W-1:0] IDLE_B = 4'hF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = 4'hF;
  logic [31:0]   rd_a, rd_b;
  logic          irq_a, irq_b;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  system_button_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_MODE(0), .IDLE_LEVEL(4'h0)) u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(rd_a), .irq(irq_a));

  system_button_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_MODE(2), .IDLE_LEVEL(IDLE_B)) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_b),
    .readdata(rd_b), .irq(irq_b));

  // Reference model, index 0 = u_a, 1 = u_b.
  logic [W-1:0] m_s1[2], m_s2[2], m_st[2], m_cap[2], m_mask[2];
  logic [31:0]  m_rd[2];
  int           m_run[2][W];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = (k == 0) ? '0 : IDLE_B;
      m_s2[k] = m_s1[k];
      m_st[k] = m_s1[k];
      m_cap[k] = '0;
      m_mask[k] = '0;
      m_rd[k] = '0;
      for (int i = 0; i < W; i++) m_run[k][i] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic wr;
    wr = chipselect && !write_n;
    for (int k = 0; k < 2; k++) begin
      logic [W-1:0] nst, chg, set, clr;
      logic [31:0]  rd;
      rd = '0;
      case (address)
        ADDR_DATA:     rd[W-1:0] = m_st[k];
        ADDR_IRQ_MASK: rd[W-1:0] = m_mask[k];
        ADDR_EDGE_CAP: rd[W-1:0] = m_cap[k];
        default:       rd = '0;
      endcase
      nst = m_st[k];
      for (int i = 0; i < W; i++) begin
        if (DB) begin
          // level accepted once the synchronised input has disagreed for D clocks in a row
          if (m_s2[k][i] != m_st[k][i]) begin
            m_run[k][i]++;
            if (m_run[k][i] == D) begin
              nst[i] = m_s2[k][i];
              m_run[k][i] = 0;
            end
          end else begin
            m_run[k][i] = 0;
          end
        end else begin
          nst[i] = m_s1[k][i];
        end
      end
      chg = nst ^ m_st[k];
      set = (k == 0) ? (chg & nst) : chg;
      clr = (wr && address == ADDR_EDGE_CAP) ? writedata[W-1:0] : '0;
      m_cap[k] = (m_cap[k] & ~clr) | set;
      if (wr && address == ADDR_IRQ_MASK) m_mask[k] = writedata[W-1:0];
      m_s2[k] = m_s1[k];
      m_s1[k] = (k == 0) ? in_a : in_b;
      m_st[k] = nst;
      m_rd[k] = rd;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("rd_a", rd_a, m_rd[0]);
    check("irq_a", {31'b0, irq_a}, {31'b0, |(m_cap[0] & m_mask[0])});
    check("rd_b", rd_b, m_rd[1]);
    check("irq_b", {31'b0, irq_b}, {31'b0, |(m_cap[1] & m_mask[1])});
  endtask

  task automatic bus(logic wr, logic [1:0] a, logic [31:0] d);
    chipselect = wr;
    write_n = ~wr;
    address = a;
    writedata = d;
  endtask

  initial begin
    // Reset with both instances at their idle levels.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_a", rd_a, 32'h0);
    check("rst_irq_a", {31'b0, irq_a}, 32'h0);
    check("rst_irq_b", {31'b0, irq_b}, 32'h0);
    reset_n = 1'b1;
    bus(1'b0, ADDR_DATA, 0);
    tick();
    check("data_a_rst", rd_a, 32'h0);
    check("data_b_idle", rd_b, 32'hF);
    bus(1'b0, ADDR_IRQ_MASK, 0);
    tick();
    check("mask_rst", rd_a, 32'h0);
    bus(1'b0, ADDR_EDGE_CAP, 0);
    repeat (D + 4) tick();
    check("cap_a_rst", rd_a, 32'h0);
    check("cap_b_idle", rd_b, 32'h0);

    // Short glitch on channel 2: filtered only when debouncing.
    in_a = 4'h4;
    repeat (5) tick();
    in_a = 4'h0;
    repeat (D + 4) tick();
    check("glitch_cap", rd_a, DB ? 32'h0 : 32'h4);
    bus(1'b1, ADDR_EDGE_CAP, 32'hF);
    tick();
    bus(1'b0, ADDR_EDGE_CAP, 0);
    repeat (D + 4) tick();

    // Held step: capture lands exactly LAT clocks after the step.
    in_a = 4'h4;
    repeat (LAT) tick();
    check("cap_early", rd_a, 32'h0);
    tick();
    check("cap_at_lat", rd_a, 32'h4);
    bus(1'b0, ADDR_DATA, 0);
    tick();
    check("data_a_step", rd_a, 32'h4);
    check("irq_unmasked", {31'b0, irq_a}, 32'h0);
    bus(1'b1, ADDR_IRQ_MASK, 32'h4);
    tick();
    check("irq_masked", {31'b0, irq_a}, 32'h1);
    bus(1'b1, ADDR_EDGE_CAP, 32'h4);
    tick();
    check("irq_cleared", {31'b0, irq_a}, 32'h0);
    bus(1'b0, ADDR_EDGE_CAP, 0);
    tick();
    check("cap_cleared", rd_a, 32'h0);

    // Any-edge channel 1 on u_b: W1C on the same edge the capture sets.
    in_b = 4'hD;
    repeat (LAT - 1) tick();
    bus(1'b1, ADDR_EDGE_CAP, 32'h2);
    tick();
    bus(1'b0, ADDR_EDGE_CAP, 0);
    tick();
    check("set_beats_clr", rd_b, 32'h2);
    in_b = 4'hF;
    repeat (LAT + 2) tick();
    bus(1'b1, ADDR_RSVD, 32'hFFFF_FFFF);
    tick();
    bus(1'b0, ADDR_RSVD, 0);
    tick();
    check("rsvd_zero", rd_a, 32'h0);

    // Randomised traffic and input activity.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) in_a = W'($urandom);
      if ($urandom_range(0, 5) == 0) in_b = W'($urandom);
      if ($urandom_range(0, 9) < 3)
        bus(1'b1, 2'($urandom), $urandom);
      else
        bus(1'b0, 2'($urandom), $urandom);
      tick();
      if (n == 300) begin
        // Reset in the middle of a debounce run.
        in_a = 4'hF;
        bus(1'b0, ADDR_EDGE_CAP, 0);
        repeat (3) tick();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_rd", rd_a, 32'h0);
        check("mid_rst_irq", {31'b0, irq_a}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
